// File: rtl/branch_resolve_predict.sv
`default_nettype none
// ============================================================================
// Module : branch_resolve_predict
// Brief  : EX-stage branch resolution, 2-bit BHT prediction, flush/redirect
//          and saturating branch/mispredict statistics.
// Rev    : 1.0  initial release
// ============================================================================
module branch_resolve_predict #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CNT_INIT  = 2'b01,
    parameter int         STAT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic [2:0]        ex_branch_sel,
    input  logic              ex_unsigned,
    input  logic              Z,
    input  logic              N,
    input  logic              C,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_target,
    output logic              MPC,
    output logic              JALR,
    output logic              flush,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mispred_count
);

    localparam int         IDX_W     = $clog2(BHT_DEPTH);
    localparam logic [2:0] c_SEL_EQ  = 3'd2;
    localparam logic [2:0] c_SEL_NE  = 3'd3;
    localparam logic [2:0] c_SEL_LT  = 3'd4;
    localparam logic [2:0] c_SEL_GE  = 3'd5;
    localparam logic [2:0] c_SEL_JAL = 3'd6;
    localparam logic [2:0] c_SEL_JALR = 3'd7;

    logic [1:0]        w_bht [BHT_DEPTH];
    logic [IDX_W-1:0]  w_if_idx;
    logic [IDX_W-1:0]  w_ex_idx;
    logic              w_cond;
    logic              w_is_cond;
    logic              w_eff;
    logic              w_mp;
    logic              w_upd;
    logic [1:0]        w_cnt_cur;
    logic [1:0]        w_cnt_nxt;

    logic              flush_q, flush_d;
    logic [XLEN-1:0]   redirect_q, redirect_d;
    logic [STAT_W-1:0] br_q, br_d;
    logic [STAT_W-1:0] mp_q, mp_d;

    assign w_if_idx      = if_pc[IDX_W+1:2];
    assign w_ex_idx      = ex_pc[IDX_W+1:2];
    assign if_pred_taken = w_bht[w_if_idx][1];

    always_comb begin
        w_cond = 1'b0;
        case (ex_branch_sel)
            c_SEL_EQ:   w_cond = Z;
            c_SEL_NE:   w_cond = ~Z;
            c_SEL_LT:   w_cond = ex_unsigned ? ~C : N;
            c_SEL_GE:   w_cond = ex_unsigned ? C : ~N;
            c_SEL_JAL:  w_cond = 1'b1;
            c_SEL_JALR: w_cond = 1'b1;
            default:    w_cond = 1'b0;
        endcase
    end

    assign MPC       = ex_valid & w_cond;
    assign JALR      = (ex_branch_sel == c_SEL_JALR);
    assign w_is_cond = (ex_branch_sel >= c_SEL_EQ) && (ex_branch_sel <= c_SEL_GE);
    // The instruction in EX while a flush is out is wrong-path and must be inert.
    assign w_eff     = ex_valid & ~flush_q;
    assign w_upd     = w_eff & w_is_cond;

    always_comb begin
        w_mp = 1'b0;
        if (w_is_cond) begin
            w_mp = (MPC != ex_pred_taken);
        end else if (ex_branch_sel == c_SEL_JAL) begin
            w_mp = ~ex_pred_taken;
        end else if (ex_branch_sel == c_SEL_JALR) begin
            w_mp = 1'b1;
        end
    end

    assign w_cnt_cur = w_bht[w_ex_idx];

    always_comb begin
        w_cnt_nxt = w_cnt_cur;
        if (MPC) begin
            if (w_cnt_cur != 2'b11) w_cnt_nxt = w_cnt_cur + 2'b01;
        end else begin
            if (w_cnt_cur != 2'b00) w_cnt_nxt = w_cnt_cur - 2'b01;
        end
    end

    generate
        for (genvar i = 0; i < BHT_DEPTH; i++) begin : g_bht
            logic [1:0] cnt_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= CNT_INIT;
                end else if (w_upd && (w_ex_idx == IDX_W'(i))) begin
                    cnt_q <= w_cnt_nxt;
                end
            end
            assign w_bht[i] = cnt_q;
        end
    endgenerate

    always_comb begin
        flush_d    = w_eff & w_mp;
        redirect_d = redirect_q;
        br_d       = br_q;
        mp_d       = mp_q;
        if (flush_d) begin
            redirect_d = MPC ? ex_target : (ex_pc + XLEN'(4));
        end
        if (w_upd && (br_q != {STAT_W{1'b1}})) begin
            br_d = br_q + STAT_W'(1);
        end
        if (flush_d && (mp_q != {STAT_W{1'b1}})) begin
            mp_d = mp_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_q    <= 1'b0;
            redirect_q <= '0;
            br_q       <= '0;
            mp_q       <= '0;
        end else begin
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            br_q       <= br_d;
            mp_q       <= mp_d;
        end
    end

    assign flush         = flush_q;
    assign redirect_pc   = redirect_q;
    assign br_count      = br_q;
    assign mispred_count = mp_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_predict.sv
`default_nettype none
// ============================================================================
// Module : tb_branch_resolve_predict
// Brief  : Scoreboard bench for branch_resolve_predict (small stats width).
// Rev    : 1.0  initial release
// ============================================================================
module tb_branch_resolve_predict;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int SW    = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     if_pc;
    logic            if_pred_taken;
    logic            ex_valid;
    logic [2:0]      ex_branch_sel;
    logic            ex_unsigned;
    logic            Z, N, C;
    logic [31:0]     ex_pc;
    logic            ex_pred_taken;
    logic [31:0]     ex_target;
    logic            MPC, JALR, flush;
    logic [31:0]     redirect_pc;
    logic [SW-1:0]   br_count, mispred_count;

    branch_resolve_predict #(
        .XLEN(XLEN), .BHT_DEPTH(DEPTH), .CNT_INIT(2'b01), .STAT_W(SW)
    ) u_dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_branch_sel(ex_branch_sel), .ex_unsigned(ex_unsigned),
        .Z(Z), .N(N), .C(C), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .ex_target(ex_target), .MPC(MPC), .JALR(JALR), .flush(flush),
        .redirect_pc(redirect_pc), .br_count(br_count), .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          flush;
        logic [31:0]   redir;
        logic [SW-1:0] br;
        logic [SW-1:0] mpc;
        logic          pred;
        logic [31:0]   pc;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    logic [1:0]    m_tbl [DEPTH];
    logic          m_flush;
    logic [31:0]   m_redir;
    logic [SW-1:0] m_br, m_mpc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = 2'b01;
        m_flush = 1'b0;
        m_redir = '0;
        m_br    = '0;
        m_mpc   = '0;
        sb.delete();
    endtask

    // Drive one EX slot, predict its effect, then compare after the edge.
    task automatic do_ex(input logic v, input logic [2:0] sel, input logic uns,
                         input logic z, input logic n, input logic c,
                         input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        logic cond, mpc, eff, mp, is_cond, fl;
        int   k;
        exp_t e;
        ex_valid = v; ex_branch_sel = sel; ex_unsigned = uns;
        Z = z; N = n; C = c; ex_pc = pc; ex_pred_taken = pred; ex_target = tgt;
        if_pc = pc;
        #1;
        case (sel)
            3'd2:    cond = z;
            3'd3:    cond = ~z;
            3'd4:    cond = uns ? ~c : n;
            3'd5:    cond = uns ? c : ~n;
            3'd6:    cond = 1'b1;
            3'd7:    cond = 1'b1;
            default: cond = 1'b0;
        endcase
        mpc     = v & cond;
        eff     = v & ~m_flush;
        is_cond = (sel >= 3'd2) && (sel <= 3'd5);
        mp      = is_cond ? (mpc != pred) : (sel == 3'd6) ? ~pred : (sel == 3'd7);
        k       = idx(pc);
        check_val("mpc", MPC, mpc);
        check_val("jalr", JALR, sel == 3'd7);
        check_val("pred_no_bypass", if_pred_taken, m_tbl[k][1]);
        fl = eff & mp;
        if (fl) m_redir = mpc ? tgt : pc + 32'd4;
        if (eff && is_cond) begin
            if (mpc && m_tbl[k] != 2'b11) m_tbl[k] = m_tbl[k] + 2'b01;
            else if (!mpc && m_tbl[k] != 2'b00) m_tbl[k] = m_tbl[k] - 2'b01;
            if (m_br != '1) m_br = m_br + 1'b1;
        end
        if (fl && m_mpc != '1) m_mpc = m_mpc + 1'b1;
        m_flush = fl;
        e.flush = fl; e.redir = m_redir; e.br = m_br; e.mpc = m_mpc;
        e.pred = m_tbl[k][1]; e.pc = pc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        e = sb.pop_front();
        if_pc = e.pc;
        #1;
        check_val("flush", flush, e.flush);
        if (e.flush) check_val("redirect_pc", redirect_pc, e.redir);
        check_val("br_count", br_count, e.br);
        check_val("mispred_count", mispred_count, e.mpc);
        check_val("pred_after", if_pred_taken, e.pred);
    endtask

    task automatic idle();
        do_ex(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_branch_sel = '0; ex_unsigned = 1'b0;
        Z = 1'b0; N = 1'b0; C = 1'b0; ex_pc = '0; ex_pred_taken = 1'b0; ex_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;

        // Reset state
        if_pc = 32'h100; #1;
        check_val("rst_pred", if_pred_taken, 1'b0);
        check_val("rst_flush", flush, 1'b0);
        check_val("rst_redirect", redirect_pc, 32'h0);
        check_val("rst_br", br_count, 0);
        check_val("rst_mp", mispred_count, 0);

        // BEQ taken, predicted not-taken
        do_ex(1, 3'd2, 0, 1, 0, 0, 32'h100, 0, 32'h200);
        check_val("beq_redirect", redirect_pc, 32'h200);
        idle();

        // BLTU not taken three times, then assorted conditions
        repeat (3) do_ex(1, 3'd4, 1, 0, 1, 1, 32'h104, 0, 32'h400);
        do_ex(1, 3'd4, 0, 0, 1, 1, 32'h108, 1, 32'h500);
        do_ex(1, 3'd5, 1, 0, 0, 0, 32'h10C, 0, 32'h600);
        do_ex(1, 3'd3, 0, 0, 0, 0, 32'h110, 1, 32'h700);
        do_ex(1, 3'd5, 0, 0, 1, 0, 32'h114, 1, 32'h780);
        idle();

        // JALR at top of address space, then not-taken wrap
        do_ex(1, 3'd7, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'h8000);
        check_val("jalr_redirect", redirect_pc, 32'h8000);
        idle();
        do_ex(1, 3'd2, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'h9000);
        check_val("wrap_redirect", redirect_pc, 32'h0);
        idle();
        do_ex(1, 3'd6, 0, 0, 0, 0, 32'h120, 0, 32'hA000);
        idle();
        do_ex(1, 3'd6, 0, 0, 0, 0, 32'h124, 1, 32'hB000);

        // Back-to-back mispredicts: second is wrong-path
        do_ex(1, 3'd2, 0, 1, 0, 0, 32'h200, 0, 32'hC000);
        do_ex(1, 3'd2, 0, 1, 0, 0, 32'h200, 0, 32'hD000);
        idle();

        // Reset while flush is pending
        do_ex(1, 3'd2, 0, 1, 0, 0, 32'h100, 0, 32'hE000);
        reset = 1'b1;
        #1;
        check_val("rst_cancel_flush", flush, 1'b0);
        check_val("rst_cancel_redirect", redirect_pc, 32'h0);
        check_val("rst_cancel_br", br_count, 0);
        check_val("rst_cancel_mp", mispred_count, 0);
        model_reset();
        if_pc = 32'h100; #1;
        check_val("rst_tbl", if_pred_taken, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        do_ex(1, 3'd2, 0, 1, 0, 0, 32'h104, 1, 32'hF000);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            do_ex($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  {24'h0, 6'($urandom), 2'b00}, 1'($urandom), $urandom);
        end

        // Statistics saturation
        for (int i = 0; i < 20; i++) begin
            do_ex(1, 3'd2, 0, 1, 0, 0, 32'h300, 0, 32'h1234);
            idle();
        end
        check_val("br_sat", br_count, 4'hF);
        check_val("mp_sat", mispred_count, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
